time_set_ctrl: RTL and testbench

//  Sequences debounced set buttons (minute, hour, day, month, year, century) into single-cycle increment strobes.

---
 rtl/time_set_ctrl_if.sv | 26 ++
 rtl/time_set_ctrl.sv | 154 +++++++++++++++
 tb/tb_time_set_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/time_set_ctrl_if.sv
// Button/strobe bundle between the debounce stage, the set controller and
// the time/date counter chain. The controller sits on the slave side:
// it consumes button levels and the mode gate, and produces strobes and status.
interface time_set_ctrl_if;
    logic [5:0] btn;
    logic       set_en;
    logic [5:0] inc_pulse;
    logic [2:0] grant_idx;
    logic       busy;

    modport master (
        output btn,
        output set_en,
        input  inc_pulse,
        input  grant_idx,
        input  busy
    );

    modport slave (
        input  btn,
        input  set_en,
        output inc_pulse,
        output grant_idx,
        output busy
    );
endinterface

// File: rtl/time_set_ctrl.sv
// time_set_ctrl
// Turns debounced set buttons (min, hrs, day, mon, year, cen) into one-hot,
// single-cycle increment strobes for the clock/calendar counters. Only one
// button owns the controller at a time: the lowest-index rising button wins,
// and every other button is ignored until all buttons have been released.
//
// Optional feature macro: TIME_SET_AUTO_REPEAT_EN
//   defined   - press-and-hold auto-repeat (first repeat after HOLD_CYC,
//               then every REP_CYC cycles)
//   undefined - exactly one strobe per press, no hold counter
module time_set_ctrl #(
    parameter int HOLD_CYC = 25_000_000,
    parameter int REP_CYC  = 5_000_000
) (
    input  logic           clk_50MHz,
    input  logic           rst,
    time_set_ctrl_if.slave bus
);

    // Strobes must never land on consecutive cycles, which needs periods of 2+.
    if (HOLD_CYC < 2 || REP_CYC < 2) begin : gBadCfg
        $error("time_set_ctrl: HOLD_CYC and REP_CYC must both be at least 2");
    end

`ifdef TIME_SET_AUTO_REPEAT_EN
    // The counter is shared by the hold and repeat phases, so size it for the larger.
    localparam int MAX_CYC = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] REP_TC  = CW'(REP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        REPEAT   = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    logic [CW-1:0] cnt_q, cnt_d;
`else
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_REL = 1'b1
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [5:0] btn_q;
    logic [5:0] pulse_q, pulse_d;
    logic [2:0] grant_q, grant_d;

    logic [5:0] rise;
    logic       riseAny;
    logic [2:0] riseIdx;
    logic       grantBtn;

    // Edge detect against the previous sample and pick the lowest-index rising button.
    always_comb begin
        rise    = bus.btn & ~btn_q;
        riseAny = |rise;
        riseIdx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (rise[i]) begin
                riseIdx = 3'(i);
            end
        end
        grantBtn = bus.btn[grant_q];
    end

    // Next-state, grant, strobe and hold-counter decisions.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        pulse_d = 6'b000000;
`ifdef TIME_SET_AUTO_REPEAT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.set_en && riseAny) begin
                    grant_d = riseIdx;
                    pulse_d = 6'b000001 << riseIdx;
`ifdef TIME_SET_AUTO_REPEAT_EN
                    state_d = HOLD;
                    cnt_d   = '0;
`else
                    state_d = WAIT_REL;
`endif
                end
            end
`ifdef TIME_SET_AUTO_REPEAT_EN
            HOLD: begin
                if (!bus.set_en || !grantBtn) begin
                    state_d = WAIT_REL;
                end else if (cnt_q == HOLD_TC) begin
                    pulse_d = 6'b000001 << grant_q;
                    cnt_d   = '0;
                    state_d = REPEAT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!bus.set_en || !grantBtn) begin
                    state_d = WAIT_REL;
                end else if (cnt_q == REP_TC) begin
                    pulse_d = 6'b000001 << grant_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            WAIT_REL: begin
                if (bus.btn == 6'b000000) begin
                    state_d = IDLE;
`ifdef TIME_SET_AUTO_REPEAT_EN
                    cnt_d   = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant, strobe and button-history registers; btn_q resets high so
    // a button already held at reset release never looks like a fresh press.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 3'd0;
            pulse_q <= 6'b000000;
            btn_q   <= 6'b111111;
`ifdef TIME_SET_AUTO_REPEAT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            pulse_q <= pulse_d;
            btn_q   <= bus.btn;
`ifdef TIME_SET_AUTO_REPEAT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.inc_pulse = pulse_q;
    assign bus.grant_idx = grant_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with HOLD_CYC=8, REP_CYC=4.
// Expectations follow the build: with TIME_SET_AUTO_REPEAT_EN defined the
// hold/repeat strobes are expected, otherwise one strobe per press.
// Cycle numbering: inputs for cycle n are sampled at clock edge n, and the
// outputs seen just after that edge are the values for cycle n+1.
module tb_time_set_ctrl;

    localparam int HOLD_CYC = 8;
    localparam int REP_CYC  = 4;
`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam bit AUTO_REP = 1'b1;
`else
    localparam bit AUTO_REP = 1'b0;
`endif

    logic clk_50MHz = 1'b0;
    logic rst;
    int   vecCount = 0;
    int   errCount = 0;

    always #10 clk_50MHz = ~clk_50MHz;

    time_set_ctrl_if busIf ();

    time_set_ctrl #(
        .HOLD_CYC (HOLD_CYC),
        .REP_CYC  (REP_CYC)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .bus       (busIf.slave)
    );

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive inputs away from the active edge, then step past one rising edge.
    task automatic applyStimulus(input logic [5:0] btn, input logic setEn);
        @(negedge clk_50MHz);
        busIf.btn    = btn;
        busIf.set_en = setEn;
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(6'b000000, 1'b1);
        end
    endtask

    initial begin
        int c;
        logic [5:0] expPulse;
        logic       expBusy;

        rst          = 1'b1;
        busIf.btn    = 6'b000000;
        busIf.set_en = 1'b1;
        repeat (2) @(posedge clk_50MHz);
        #1;
        checkOutput("reset.pulse", busIf.inc_pulse, 6'b000000);
        checkOutput("reset.grant", busIf.grant_idx, 3'd0);
        checkOutput("reset.busy",  busIf.busy, 1'b0);
        @(negedge clk_50MHz);
        rst = 1'b0;
        idleCycles(2);

        // Test 1: tap btn[0] for cycles 0-2
        for (int n = 0; n < 6; n++) begin
            c = n + 1;
            applyStimulus((n <= 2) ? 6'b000001 : 6'b000000, 1'b1);
            expPulse = (c == 1) ? 6'b000001 : 6'b000000;
            expBusy  = (c >= 1 && c <= 3) || (AUTO_REP && c == 4);
            checkOutput("tap.pulse", busIf.inc_pulse, expPulse);
            checkOutput("tap.busy",  busIf.busy, expBusy);
        end
        idleCycles(2);

        // Test 2: hold btn[1] for cycles 0-19
        for (int n = 0; n < 24; n++) begin
            c = n + 1;
            applyStimulus((n <= 19) ? 6'b000010 : 6'b000000, 1'b1);
            expPulse = ((c == 1) || (AUTO_REP && (c == 9 || c == 13 || c == 17)))
                       ? 6'b000010 : 6'b000000;
            expBusy  = (c <= 20) || (AUTO_REP && c == 21);
            checkOutput("hold.pulse", busIf.inc_pulse, expPulse);
            checkOutput("hold.busy",  busIf.busy, expBusy);
            if (c == 1) begin
                checkOutput("hold.grant", busIf.grant_idx, 3'd1);
            end
        end
        idleCycles(2);

        // Test 3: btn[2] and btn[4] together; btn[4] must not win until re-pressed
        for (int n = 0; n < 18; n++) begin
            logic [5:0] b;
            c = n + 1;
            if (n <= 3)       b = 6'b010100;
            else if (n <= 9)  b = 6'b010000;
            else if (n <= 11) b = 6'b000000;
            else if (n <= 14) b = 6'b010000;
            else              b = 6'b000000;
            applyStimulus(b, 1'b1);
            expPulse = (c == 1) ? 6'b000100 : (c == 13) ? 6'b010000 : 6'b000000;
            checkOutput("contend.pulse", busIf.inc_pulse, expPulse);
            if (c == 1) begin
                checkOutput("contend.grant2", busIf.grant_idx, 3'd2);
            end
            if (c == 13) begin
                checkOutput("contend.grant4", busIf.grant_idx, 3'd4);
            end
        end
        idleCycles(2);

        // Test 4a: btn[3] tapped with set mode off
        for (int n = 0; n < 5; n++) begin
            applyStimulus((n <= 2) ? 6'b001000 : 6'b000000, 1'b0);
            checkOutput("gate.pulse", busIf.inc_pulse, 6'b000000);
            checkOutput("gate.busy",  busIf.busy, 1'b0);
        end
        idleCycles(2);

        // Test 4b: set_en dropped on the edge of a repeat terminal count on btn[5]
        for (int n = 0; n < 19; n++) begin
            c = n + 1;
            applyStimulus((n <= 15) ? 6'b100000 : 6'b000000, (n < 12));
            expPulse = ((c == 1) || (AUTO_REP && c == 9)) ? 6'b100000 : 6'b000000;
            expBusy  = (c <= 16);
            checkOutput("modeoff.pulse", busIf.inc_pulse, expPulse);
            checkOutput("modeoff.busy",  busIf.busy, expBusy);
        end
        idleCycles(2);

        // Test 5: reset mid-press on btn[0], button held through and after reset
        for (int n = 0; n < 4; n++) begin
            c = n + 1;
            applyStimulus(6'b000001, 1'b1);
            checkOutput("prerst.pulse", busIf.inc_pulse, (c == 1) ? 6'b000001 : 6'b000000);
        end
        @(negedge clk_50MHz);
        rst = 1'b1;
        #1;
        checkOutput("midrst.busy",  busIf.busy, 1'b0);
        checkOutput("midrst.pulse", busIf.inc_pulse, 6'b000000);
        @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            applyStimulus(6'b000001, 1'b1);
            checkOutput("heldrst.pulse", busIf.inc_pulse, 6'b000000);
            checkOutput("heldrst.busy",  busIf.busy, 1'b0);
        end
        idleCycles(2);
        for (int n = 0; n < 5; n++) begin
            c = n + 1;
            applyStimulus((n <= 2) ? 6'b000001 : 6'b000000, 1'b1);
            checkOutput("repress.pulse", busIf.inc_pulse, (c == 1) ? 6'b000001 : 6'b000000);
        end
        idleCycles(2);
        checkOutput("final.busy", busIf.busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
